serial_remainder_fsm: RTL and testbench
=======================================

# serial_remainder_fsm

Parametrised serial divisibility checker. It accepts one bit per valid cycle of an arbitrarily long binary number and keeps the running remainder modulo a compile-time `DIVISOR`. It reports both the remainder and a divisibility flag, plus a saturating bit counter and an output-valid strobe. It replaces fixed-modulus serial checkers in the FSM exercise set and serves as a reference remainder unit for testbenches.

## Interface
- `DIVISOR`, 5, modulus N; legal range 2..256.
- `CNT_W`, 8, width of the accepted-bit counter.
- `REM_W`, derived localparam, `$clog2(DIVISOR)`; not overridable.
- `clk`, input, 1, single clock; all state changes on its rising edge.
- `rst`, input, 1, asynchronous, active-low reset.
- `clear`, input, 1, synchronous return to the empty-number state.
- `in_valid`, input, 1, `in_bit` is accepted this cycle.
- `in_first`, input, 1, the accepted bit starts a new number; qualified by `in_valid`.
- `in_bit`, input, 1, next bit of the number.
- `out_valid`, output, 1, one-cycle strobe: outputs reflect a newly accepted bit.
- `rem`, output, REM_W, running remainder, always in 0..N-1.
- `divisible`, output, 1, high when `rem == 0`.
- `bit_count`, output, CNT_W, bits accepted in the current number; saturates.
- `count_sat`, output, 1, sticky flag: `bit_count` has reached all-ones.

## Operation
- States:
  - EMPTY: no bits accepted; remainder 0.
  - ACCUM: at least one bit accepted.
- Transitions:
  - EMPTY → ACCUM on an accepted bit.
  - ACCUM → EMPTY only on `clear` or reset.
  - An accepted `in_first` stays in or enters ACCUM and restarts accumulation.
- MSB-first update, the default order:
  - Compute t = 2·rem + in_bit at REM_W+1 bits.
  - rem' = t − N if t ≥ N, else t.
  - No divider or multiplier. A single conditional subtract suffices because t ≤ 2N−1.
- On an accepted `in_first`, the prior state is discarded: rem' = in_bit, bit_count' = 1, count_sat' = 0.
- Empty number is value 0: `divisible` = 1 in EMPTY.
- `bit_count` increments per accepted bit and holds at 2^CNT_W−1. `count_sat` sets when that value is reached and clears only on `in_first`, `clear` or reset.
- The remainder is exact regardless of counter saturation; the number length is unbounded.
- `in_valid` = 0: all state holds, `out_valid` = 0. `in_first` and `in_bit` are ignored.
- `clear` with `in_valid` in the same cycle: `clear` wins, the bit is dropped, and `out_valid` = 0.
- Reset values:
  - `rem` = 0, `divisible` = 1, `bit_count` = 0, `count_sat` = 0, `out_valid` = 0.
  - State = EMPTY; LSB weight register = 1.

## Timing
- All outputs are registered. A bit accepted at edge k is reflected in `rem`, `divisible` and `bit_count`, with `out_valid` = 1, during the cycle after edge k.
- Latency is 1 cycle; throughput is 1 bit/cycle with no stalls. There is no backpressure.
- `divisible` is coherent with `rem` in the same cycle; it is never derived one cycle late.
- Asserting `rst` low mid-number forces reset values immediately, without waiting for a clock edge. Release is synchronous to `clk` at the integration level.
- `clear` takes effect at the next edge; outputs show reset values in the following cycle.

## Configuration
- `SERIAL_REM_LSB_FIRST_EN` defined: bits arrive LSB-first.
  - Adds a weight register w (REM_W bits) holding 2^i mod N, which resets to 1.
  - Update: rem' = (rem + in_bit·w) mod N by conditional subtract; w' = 2w mod N by conditional subtract.
  - On `in_first`: rem' = in_bit, w' = 2 mod N.
  - On `clear` or reset: w = 1.
- Not defined: MSB-first only. No weight register is built.
- Port list and timing are identical in both builds.

## Test plan
- N=5, MSB-first, `in_first` on bit 0, bits 1,0,1,0 → `rem` 1,2,0,0; `divisible` 0,0,1,1; `out_valid` high each following cycle.
- N=7, MSB-first, bits 1,1,1,1 → `rem` 1,3,0,1; `bit_count` 1,2,3,4.
- CNT_W=3, N=3, 9 consecutive 1-bits → `bit_count` saturates at 7 with `count_sat` = 1 from the 7th bit; `rem` after 9 bits = 511 mod 3 = 1.
- N=5, bits 1,1 (rem 3), then `in_first` with bit 1 → `rem` 1, `bit_count` 1, `count_sat` 0. Then `clear` together with `in_valid` → bit dropped; next cycle `rem` 0, `divisible` 1, `out_valid` 0.
- N=5, bits 1,1,0, `rst` pulsed low between edges → all outputs at reset values immediately. Then bits 1,0,1 → `rem` 1,2,0.
- With `SERIAL_REM_LSB_FIRST_EN` and N=5: bits 1,0,1 (value 5) → `rem` 1,1,0. Then bit 1 (value 13) → `rem` 3.

Source files
------------

// File: rtl/serial_remainder_fsm.sv
// Serial divisibility checker: running remainder modulo DIVISOR of a bit-serial number.
// Bits arrive MSB-first by default; defining SERIAL_REM_LSB_FIRST_EN switches to LSB-first.
module serial_remainder_fsm #(
    parameter int unsigned DIVISOR = 5,
    parameter int unsigned CNT_W   = 8,
    localparam int unsigned REM_W  = $clog2(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic             in_bit,
    output logic             out_valid,
    output logic [REM_W-1:0] rem,
    output logic             divisible,
    output logic [CNT_W-1:0] bit_count,
    output logic             count_sat
);

    localparam int unsigned REM_X = REM_W + 1;
    localparam logic [REM_X-1:0] N_EXT   = REM_X'(DIVISOR);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_ACCUM = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               ov_q, ov_d;
    logic               div_q, div_d;
    logic [REM_W-1:0]   rem_next_c;
    logic [REM_W-1:0]   rem_first_c;
    logic [CNT_W-1:0]   cnt_inc_c;

`ifdef SERIAL_REM_LSB_FIRST_EN
    localparam logic [REM_W-1:0] TWO_MOD_N = REM_W'(2 % DIVISOR);
    logic [REM_W-1:0]   w_q, w_d;
    logic [REM_X-1:0]   sum_c;
    logic [REM_X-1:0]   w2_c;
    logic [REM_W-1:0]   w_next_c;

    // rem + bit*w and 2w each stay below 2N, so one conditional subtract reduces them.
    always_comb begin
        sum_c      = {1'b0, rem_q} + (in_bit ? {1'b0, w_q} : REM_X'(0));
        rem_next_c = (sum_c >= N_EXT) ? REM_W'(sum_c - N_EXT) : REM_W'(sum_c);
        w2_c       = {w_q, 1'b0};
        w_next_c   = (w2_c >= N_EXT) ? REM_W'(w2_c - N_EXT) : REM_W'(w2_c);
    end
`else
    logic [REM_X-1:0]   t_c;

    // t = 2*rem + bit is at most 2N-1, so one conditional subtract reduces it.
    always_comb begin
        t_c        = {rem_q, in_bit};
        rem_next_c = (t_c >= N_EXT) ? REM_W'(t_c - N_EXT) : REM_W'(t_c);
    end
`endif

    assign rem_first_c = REM_W'(in_bit);
    assign cnt_inc_c   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_EMPTY;
            rem_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            ov_q    <= 1'b0;
            div_q   <= 1'b1;
`ifdef SERIAL_REM_LSB_FIRST_EN
            w_q     <= REM_W'(1);
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            ov_q    <= ov_d;
            div_q   <= div_d;
`ifdef SERIAL_REM_LSB_FIRST_EN
            w_q     <= w_d;
`endif
        end
    end

    // Next state: clear returns to EMPTY, any accepted bit lands in ACCUM.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_EMPTY;
        end else if (in_valid) begin
            state_d = S_ACCUM;
        end
    end

    // Output/datapath next values; clear beats a same-cycle bit.
    always_comb begin
        rem_d = rem_q;
        cnt_d = cnt_q;
        sat_d = sat_q;
        ov_d  = 1'b0;
`ifdef SERIAL_REM_LSB_FIRST_EN
        w_d   = w_q;
`endif
        if (clear) begin
            rem_d = '0;
            cnt_d = '0;
            sat_d = 1'b0;
`ifdef SERIAL_REM_LSB_FIRST_EN
            w_d   = REM_W'(1);
`endif
        end else if (in_valid) begin
            ov_d = 1'b1;
            if (in_first) begin
                rem_d = rem_first_c;
                cnt_d = CNT_W'(1);
                sat_d = 1'b0;
`ifdef SERIAL_REM_LSB_FIRST_EN
                w_d   = TWO_MOD_N;
`endif
            end else begin
                rem_d = rem_next_c;
                cnt_d = cnt_inc_c;
                sat_d = sat_q | (cnt_inc_c == CNT_MAX);
`ifdef SERIAL_REM_LSB_FIRST_EN
                w_d   = w_next_c;
`endif
            end
        end
        div_d = (rem_d == '0);
    end

    assign out_valid = ov_q;
    assign rem       = rem_q;
    assign divisible = div_q;
    assign bit_count = cnt_q;
    assign count_sat = sat_q;

endmodule

// File: tb/tb_serial_remainder_fsm.sv
// Self-checking bench for serial_remainder_fsm: three parameterisations against an arithmetic model.
// Honours SERIAL_REM_LSB_FIRST_EN to pick the bit order of the model and directed vectors.
module tb_serial_remainder_fsm;

    logic clk;
    logic rst;
    logic clear;
    logic in_valid;
    logic in_first;
    logic in_bit;

    logic       ov0, ov1, ov2;
    logic       div0, div1, div2;
    logic       sat0, sat1, sat2;
    logic [2:0] rem0, rem1;
    logic [1:0] rem2;
    logic [7:0] cnt0, cnt1;
    logic [2:0] cnt2;

    int checks = 0;
    int errors = 0;

    int n_a[3]  = '{5, 7, 3};
    int cmax[3] = '{255, 255, 7};
    int m_rem[3];
    int m_cnt[3];
    int m_sat[3];
    int m_ov;
`ifdef SERIAL_REM_LSB_FIRST_EN
    int m_w[3];
`endif

    serial_remainder_fsm #(.DIVISOR(5), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_first(in_first),
        .in_bit(in_bit), .out_valid(ov0), .rem(rem0), .divisible(div0),
        .bit_count(cnt0), .count_sat(sat0));

    serial_remainder_fsm #(.DIVISOR(7), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_first(in_first),
        .in_bit(in_bit), .out_valid(ov1), .rem(rem1), .divisible(div1),
        .bit_count(cnt1), .count_sat(sat1));

    serial_remainder_fsm #(.DIVISOR(3), .CNT_W(3)) u2 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_first(in_first),
        .in_bit(in_bit), .out_valid(ov2), .rem(rem2), .divisible(div2),
        .bit_count(cnt2), .count_sat(sat2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_rem[k] = 0;
            m_cnt[k] = 0;
            m_sat[k] = 0;
`ifdef SERIAL_REM_LSB_FIRST_EN
            m_w[k] = 1;
`endif
        end
        m_ov = 0;
    endtask

    // Value of the number modulo N, tracked with plain integer arithmetic.
    task automatic model_step(input logic v, input logic f, input logic b, input logic c);
        if (c) begin
            model_reset();
        end else if (v) begin
            m_ov = 1;
            for (int k = 0; k < 3; k++) begin
                if (f) begin
                    m_rem[k] = int'(b);
                    m_cnt[k] = 1;
                    m_sat[k] = 0;
`ifdef SERIAL_REM_LSB_FIRST_EN
                    m_w[k] = 2 % n_a[k];
`endif
                end else begin
`ifdef SERIAL_REM_LSB_FIRST_EN
                    m_rem[k] = (m_rem[k] + int'(b) * m_w[k]) % n_a[k];
                    m_w[k]   = (2 * m_w[k]) % n_a[k];
`else
                    m_rem[k] = (2 * m_rem[k] + int'(b)) % n_a[k];
`endif
                    if (m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
                    if (m_cnt[k] == cmax[k]) m_sat[k] = 1;
                end
            end
        end else begin
            m_ov = 0;
        end
    endtask

    task automatic check_models();
        logic [31:0] o_rem[3];
        logic [31:0] o_cnt[3];
        logic [31:0] o_div[3];
        logic [31:0] o_sat[3];
        logic [31:0] o_ov[3];
        o_rem[0] = 32'(rem0); o_rem[1] = 32'(rem1); o_rem[2] = 32'(rem2);
        o_cnt[0] = 32'(cnt0); o_cnt[1] = 32'(cnt1); o_cnt[2] = 32'(cnt2);
        o_div[0] = 32'(div0); o_div[1] = 32'(div1); o_div[2] = 32'(div2);
        o_sat[0] = 32'(sat0); o_sat[1] = 32'(sat1); o_sat[2] = 32'(sat2);
        o_ov[0]  = 32'(ov0);  o_ov[1]  = 32'(ov1);  o_ov[2]  = 32'(ov2);
        for (int k = 0; k < 3; k++) begin
            chk("rem", k, o_rem[k], 32'(m_rem[k]));
            chk("divisible", k, o_div[k], (m_rem[k] == 0) ? 32'd1 : 32'd0);
            chk("bit_count", k, o_cnt[k], 32'(m_cnt[k]));
            chk("count_sat", k, o_sat[k], 32'(m_sat[k]));
            chk("out_valid", k, o_ov[k], 32'(m_ov));
        end
    endtask

    task automatic step(input logic v, input logic f, input logic b, input logic c);
        in_valid = v;
        in_first = f;
        in_bit   = b;
        clear    = c;
        @(posedge clk);
        #1;
        model_step(v, f, b, c);
        check_models();
    endtask

    initial begin
        int exp_a[4];
        rst      = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_bit   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_models();
        chk("reset_divisible", 0, 32'(div0), 32'd1);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);

`ifndef SERIAL_REM_LSB_FIRST_EN
        // N=5, 1010 with in_first on the first bit.
        exp_a = '{1, 2, 0, 0};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i == 0), (i % 2 == 0), 1'b0);
            chk("tp1_rem", 0, 32'(rem0), 32'(exp_a[i]));
            chk("tp1_div", 0, 32'(div0), (exp_a[i] == 0) ? 32'd1 : 32'd0);
            chk("tp1_ov", 0, 32'(ov0), 32'd1);
        end
        // N=7, 1111.
        exp_a = '{1, 3, 0, 1};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i == 0), 1'b1, 1'b0);
            chk("tp2_rem", 1, 32'(rem1), 32'(exp_a[i]));
            chk("tp2_cnt", 1, 32'(cnt1), 32'(i + 1));
        end
`endif

        // CNT_W=3, N=3: nine ones saturate the counter at 7.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            chk("tp3_cnt", 2, 32'(cnt2), (i < 7) ? 32'(i + 1) : 32'd7);
            chk("tp3_sat", 2, 32'(sat2), (i >= 6) ? 32'd1 : 32'd0);
        end
        chk("tp3_rem", 2, 32'(rem2), 32'd1);

        // N=5: 11 gives 3 in either order, then in_first restarts, then clear drops a bit.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("tp4_rem3", 0, 32'(rem0), 32'd3);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("tp4_first_rem", 0, 32'(rem0), 32'd1);
        chk("tp4_first_cnt", 0, 32'(cnt0), 32'd1);
        chk("tp4_first_sat", 0, 32'(sat0), 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("tp4_clear_rem", 0, 32'(rem0), 32'd0);
        chk("tp4_clear_div", 0, 32'(div0), 32'd1);
        chk("tp4_clear_ov", 0, 32'(ov0), 32'd0);

        // Asynchronous reset mid-number, then a fresh number.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b0;
        #2;
        model_reset();
        check_models();
        chk("tp5_rst_div", 0, 32'(div0), 32'd1);
        rst = 1'b1;
`ifdef SERIAL_REM_LSB_FIRST_EN
        exp_a = '{1, 1, 0, 3};
`else
        exp_a = '{1, 2, 0, 1};
`endif
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, (i != 1), 1'b0);
            chk("tp5_rem", 0, 32'(rem0), 32'(exp_a[i]));
        end

        // Long run to saturate the 8-bit counters.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        chk("long_sat", 0, 32'(sat0), 32'd1);

        // Randomised traffic, including ignored in_first/in_bit while idle.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
